// File: rtl/ddr3_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// ddr3_cmd_scheduler
//
// Two-port DDR3 command scheduler. It picks one scalar read/write request at a
// time (round-robin between the ports) and keeps an open-page row table for
// the 8 banks. It emits PRE/ACT/RD/WR on the shared command pins. Per-bank and
// global timers enforce tRCD, tRP, tRAS, tRRD and tCCD.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        asynchronous, active-low reset
//   ready        DDR3 init complete; no new request is locked while low
//   req_valid    per-port request valid (held until its req_ready pulse)
//   req_write    per-port direction, 1 = write
//   req_addr     port p uses [26p+25:26p] = {bank[2:0], row[12:0], col[9:0]}
//   req_ready    one-cycle pulse to the port whose RD/WR is on the pins
//   cs_bar, ras_bar, cas_bar, we_bar, BA, A   registered DDR3 command bus
//   issue_valid  pulses with every RD/WR
//   issue_write  1 when the issued column command is WR (0 otherwise)
//   issue_port   port of the issued column command (0 otherwise)
// ---------------------------------------------------------------------------
module ddr3_cmd_scheduler #(
  parameter int TRCD = 16,
  parameter int TRP  = 16,
  parameter int TRAS = 40,
  parameter int TRRD = 8,
  parameter int TCCD = 8,
  parameter int TW   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [51:0] req_addr,
  output logic [1:0]  req_ready,
  output logic        cs_bar,
  output logic        ras_bar,
  output logic        cas_bar,
  output logic        we_bar,
  output logic [2:0]  BA,
  output logic [12:0] A,
  output logic        issue_valid,
  output logic        issue_write,
  output logic        issue_port
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [TW-1:0] T_MAX = '1;
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [TW-1:0] T_RCD = TW'(TRCD);
  localparam logic [TW-1:0] T_RP  = TW'(TRP);
  localparam logic [TW-1:0] T_RAS = TW'(TRAS);
  localparam logic [TW-1:0] T_RRD = TW'(TRRD);
  localparam logic [TW-1:0] T_CCD = TW'(TCCD);

  typedef enum logic [1:0] {S_ARB, S_PRE, S_ACT, S_COL} state_t;

  state_t          state, state_n;

  // Timers are loaded with 1 on the edge that registers the command, so a
  // decision taken with age >= T puts the dependent command on the pins
  // exactly T cycles (or more) after the earlier one.
  logic [TW-1:0]   act_age [8];
  logic [TW-1:0]   pre_age [8];
  logic [TW-1:0]   last_act;
  logic [TW-1:0]   last_col;
  logic [7:0]      bank_open;
  logic [12:0]     open_row [8];
  logic            last_port;

  logic            lck_port;
  logic            lck_write;
  logic [2:0]      lck_bank;
  logic [12:0]     lck_row;
  logic [9:0]      lck_col;

  logic [3:0]      cmd_q, cmd_n;
  logic [2:0]      ba_n;
  logic [12:0]     a_n;
  logic [1:0]      rr_n;
  logic            iv_n, iw_n, ip_n;
  logic            lock, do_act, do_pre, do_col;

  logic [1:0]      elig;
  logic            win_port;
  logic [25:0]     sel_addr;
  logic [2:0]      sel_bank;
  logic [12:0]     sel_row;
  logic            sel_hit;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    return (t == T_MAX) ? t : t + 1'b1;
  endfunction

  assign {cs_bar, ras_bar, cas_bar, we_bar} = cmd_q;

  // Arbitration. A port whose req_ready is pulsing this cycle is still
  // showing the request that was just served, so it is masked out.
  always_comb begin
    elig = req_valid & ~req_ready;
    if (elig == 2'b11) win_port = ~last_port;
    else               win_port = elig[1];
    sel_addr = win_port ? req_addr[51:26] : req_addr[25:0];
    sel_bank = sel_addr[25:23];
    sel_row  = sel_addr[22:10];
    sel_hit  = bank_open[sel_bank] && (open_row[sel_bank] == sel_row);
  end

  // Next state and next command
  always_comb begin
    state_n = state;
    cmd_n   = CMD_NOP;
    ba_n    = BA;
    a_n     = A;
    rr_n    = 2'b00;
    iv_n    = 1'b0;
    iw_n    = 1'b0;
    ip_n    = 1'b0;
    lock    = 1'b0;
    do_act  = 1'b0;
    do_pre  = 1'b0;
    do_col  = 1'b0;
    case (state)
      S_ARB: begin
        if (ready && (elig != 2'b00)) begin
          lock = 1'b1;
          if (!bank_open[sel_bank]) state_n = S_ACT;
          else if (sel_hit)         state_n = S_COL;
          else                      state_n = S_PRE;
        end
      end
      S_PRE: begin
        if (act_age[lck_bank] >= T_RAS) begin
          do_pre  = 1'b1;
          cmd_n   = CMD_PRE;
          ba_n    = lck_bank;
          a_n     = 13'd0;
          state_n = S_ACT;
        end
      end
      S_ACT: begin
        if ((pre_age[lck_bank] >= T_RP) && (last_act >= T_RRD)) begin
          do_act  = 1'b1;
          cmd_n   = CMD_ACT;
          ba_n    = lck_bank;
          a_n     = lck_row;
          state_n = S_COL;
        end
      end
      S_COL: begin
        if ((act_age[lck_bank] >= T_RCD) && (last_col >= T_CCD)) begin
          do_col         = 1'b1;
          cmd_n          = lck_write ? CMD_WR : CMD_RD;
          ba_n           = lck_bank;
          a_n            = {3'b000, lck_col};
          rr_n[lck_port] = 1'b1;
          iv_n           = 1'b1;
          iw_n           = lck_write;
          ip_n           = lck_port;
          state_n        = S_ARB;
        end
      end
      default: state_n = S_ARB;
    endcase
  end

  // Control registers, command outputs and timers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_ARB;
      cmd_q       <= CMD_NOP;
      BA          <= 3'd0;
      A           <= 13'd0;
      req_ready   <= 2'b00;
      issue_valid <= 1'b0;
      issue_write <= 1'b0;
      issue_port  <= 1'b0;
      last_port   <= 1'b1;
      bank_open   <= 8'h00;
      last_act    <= T_MAX;
      last_col    <= T_MAX;
      for (int b = 0; b < 8; b++) begin
        act_age[b] <= T_MAX;
        pre_age[b] <= T_MAX;
      end
    end else begin
      state       <= state_n;
      cmd_q       <= cmd_n;
      BA          <= ba_n;
      A           <= a_n;
      req_ready   <= rr_n;
      issue_valid <= iv_n;
      issue_write <= iw_n;
      issue_port  <= ip_n;
      if (do_col) last_port <= lck_port;
      if (do_act) bank_open[lck_bank] <= 1'b1;
      if (do_pre) bank_open[lck_bank] <= 1'b0;
      last_act <= do_act ? T_ONE : sat_inc(last_act);
      last_col <= do_col ? T_ONE : sat_inc(last_col);
      for (int b = 0; b < 8; b++) begin
        act_age[b] <= (do_act && (lck_bank == 3'(b))) ? T_ONE : sat_inc(act_age[b]);
        pre_age[b] <= (do_pre && (lck_bank == 3'(b))) ? T_ONE : sat_inc(pre_age[b]);
      end
    end
  end

  // Locked request and open-row table; only read while the matching
  // state / bank_open bit says they are valid.
  always_ff @(posedge clk) begin
    if (lock) begin
      lck_port  <= win_port;
      lck_write <= req_write[win_port];
      lck_bank  <= sel_bank;
      lck_row   <= sel_row;
      lck_col   <= sel_addr[9:0];
    end
    if (do_act) open_row[lck_bank] <= lck_row;
  end

endmodule
